key_conditioner: RTL and testbench

//  Conditions the four raw active-low push-buttons (KEY[3:0]) before they reach the input

---
 rtl/key_conditioner_pkg.sv | 16 +
 rtl/key_conditioner_debounce_bit.sv | 61 ++++++
 rtl/key_conditioner.sv | 96 +++++++++
 tb/tb_key_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared constants for the push-button conditioning path.
// KEY_IDX_W is imported by every block that carries a key index.
package key_conditioner_pkg;

  localparam int unsigned KEY_N_KEYS          = 4;
  localparam int unsigned KEY_IDX_W           = 2;
  localparam int unsigned KEY_DEBOUNCE_CYCLES = 250000;  // 5 ms at 50 MHz

  // Smallest counter width with 2**w > cycles.
  function automatic int unsigned key_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned KEY_CNT_W = key_cnt_w(KEY_DEBOUNCE_CYCLES);

endpackage

// File: rtl/key_conditioner_debounce_bit.sv
// debounce_bit: one push-button lane.
//   clock     in  system clock
//   reset     in  synchronous, active-high reset
//   i_key_n   in  raw button, active-low, asynchronous to clock
//   o_level   out debounced level, active-high
//   o_press   out one-cycle pulse in the first cycle o_level is high
module debounce_bit
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = key_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser; inversion happens on the way in so everything
  // downstream is active-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= ~i_key_n;
      r_s2 <= r_s1;
    end
  end

  // Any sample that agrees with the accepted level restarts the count, so
  // only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_stable;
  assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects the raw
// active-low KEY buttons and latches the first new press in a one-entry
// event register drained by a consume handshake.
//   clock          in  system clock
//   reset          in  synchronous, active-high reset
//   key_n          in  raw buttons, active-low
//   key_level      out debounced levels, active-high
//   key_press      out one-cycle pulse per debounced press
//   any_held       out OR of key_level
//   event_valid    out event register holds an unconsumed press
//   event_key      out lowest pressed index of the latched event
//   event_multi    out more than one key pressed when latched
//   event_consume  in  consumer accepts the event (ignored while empty)
//   overflow       out sticky: a press was dropped because the register was full
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned N_KEYS          = KEY_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = key_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_KEYS-1:0]    key_n,
  output logic [N_KEYS-1:0]    key_level,
  output logic [N_KEYS-1:0]    key_press,
  output logic                 any_held,
  output logic                 event_valid,
  output logic [KEY_IDX_W-1:0] event_key,
  output logic                 event_multi,
  input  logic                 event_consume,
  output logic                 overflow
);

  logic [N_KEYS-1:0]    w_press;
  logic [KEY_IDX_W-1:0] w_low_idx;
  logic                 w_multi;
  logic                 w_any_press;
  logic                 w_load_ok;

  logic                 r_valid;
  logic [KEY_IDX_W-1:0] r_key;
  logic                 r_multi;
  logic                 r_overflow;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .i_key_n (key_n[g]),
      .o_level (key_level[g]),
      .o_press (w_press[g])
    );
  end

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    w_low_idx = '0;
    for (int unsigned i = N_KEYS; i > 0; i--) begin
      if (w_press[i-1]) w_low_idx = KEY_IDX_W'(i - 1);
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign w_multi     = |(w_press & (w_press - N_KEYS'(1)));
  assign w_any_press = |w_press;
  assign w_load_ok   = ~r_valid | event_consume;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_key      <= '0;
      r_multi    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_any_press && w_load_ok) begin
      r_valid <= 1'b1;
      r_key   <= w_low_idx;
      r_multi <= w_multi;
    end else if (w_any_press) begin
      r_overflow <= 1'b1;
    end else if (event_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign key_press   = w_press;
  assign any_held    = |key_level;
  assign event_valid = r_valid;
  assign event_key   = r_key;
  assign event_multi = r_multi;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int unsigned D = 4;

  logic       clock;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic       any_held;
  logic       event_valid;
  logic [1:0] event_key;
  logic       event_multi;
  logic       event_consume;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  key_conditioner #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .key_level     (key_level),
    .key_press     (key_press),
    .any_held      (any_held),
    .event_valid   (event_valid),
    .event_key     (event_key),
    .event_multi   (event_multi),
    .event_consume (event_consume),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: a level flips once the last D synchronised samples all
  // disagree with it; samples reach the comparator two clocks after key_n.
  logic [3:0] m_hist [0:D+1];   // m_hist[0] = newest sampled ~key_n
  logic [3:0] m_level;
  logic [3:0] m_prev;
  logic       m_valid;
  logic [1:0] m_key;
  logic       m_multi;
  logic       m_ovf;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i <= D + 1; i++) m_hist[i] = 4'b0000;
    m_level = '0; m_prev = '0;
    m_valid = 1'b0; m_key = '0; m_multi = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] p;
    logic       c;
    logic       r;
    logic [3:0] s;
    logic       all_diff;
    p = m_level & ~m_prev;
    c = event_consume;
    r = reset;
    s = ~key_n;
    @(posedge clock);
    if (r) begin
      model_reset();
    end else begin
      if (p != 0 && (!m_valid || c)) begin
        m_valid = 1'b1;
        m_multi = ($countones(p) > 1);
        for (int k = 3; k >= 0; k--) if (p[k]) m_key = 2'(k);
      end else if (p != 0) begin
        m_ovf = 1'b1;
      end else if (c) begin
        m_valid = 1'b0;
      end
      for (int unsigned i = D + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s;
      m_prev = m_level;
      for (int unsigned b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int unsigned j = 2; j <= D + 1; j++)
          if (m_hist[j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) m_level[b] = ~m_level[b];
      end
    end
    #1;
    chk("key_level",   key_level,           m_level);
    chk("key_press",   key_press,           m_level & ~m_prev);
    chk("any_held",    {3'b0, any_held},    {3'b0, |m_level});
    chk("event_valid", {3'b0, event_valid}, {3'b0, m_valid});
    chk("event_key",   {2'b0, event_key},   {2'b0, m_key});
    chk("event_multi", {3'b0, event_multi}, {3'b0, m_multi});
    chk("overflow",    {3'b0, overflow},    {3'b0, m_ovf});
  endtask

  initial begin
    reset = 1'b1;
    key_n = 4'b1111;
    event_consume = 1'b0;
    model_reset();

    // 1. reset then idle
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("t1_idle", {key_level[2:0], event_valid}, 4'b0000);

    // 2. clean press of key 2
    key_n[2] = 1'b0;
    repeat (5) tick();
    chk("t2_level_c5", key_level, 4'b0000);
    tick();
    chk("t2_level_c6", key_level, 4'b0100);
    chk("t2_press_c6", key_press, 4'b0100);
    tick();
    chk("t2_press_c7", key_press, 4'b0000);
    chk("t2_event", {event_valid, event_multi, event_key}, 4'b1010);
    event_consume = 1'b1;
    tick();
    event_consume = 1'b0;
    chk("t2_consumed", {3'b0, event_valid}, 4'b0000);

    // 3. short glitch on key 1
    key_n[1] = 1'b0;
    repeat (3) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    chk("t3_level", key_level, 4'b0100);
    chk("t3_valid", {3'b0, event_valid}, 4'b0000);

    // 4. keys 0 and 3 together
    key_n = 4'b1111;
    repeat (8) tick();
    key_n = 4'b0110;
    repeat (6) tick();
    chk("t4_press", key_press, 4'b1001);
    tick();
    chk("t4_event", {event_valid, event_multi, event_key}, 4'b1100);
    event_consume = 1'b1;
    tick();
    event_consume = 1'b0;
    key_n = 4'b1111;
    repeat (8) tick();

    // 5. overflow, then consume coinciding with a new press
    key_n[1] = 1'b0;
    repeat (7) tick();
    chk("t5_first", {event_valid, overflow, event_key}, 4'b1001);
    key_n[3] = 1'b0;
    repeat (7) tick();
    chk("t5_ovf", {event_valid, overflow, event_key}, 4'b1101);
    key_n[2] = 1'b0;
    repeat (6) tick();
    chk("t5_press2", key_press, 4'b0100);
    event_consume = 1'b1;
    tick();
    event_consume = 1'b0;
    chk("t5_replace", {event_valid, event_multi, event_key}, 4'b1010);

    // 6. reset mid-debounce
    reset = 1'b1;
    key_n = 4'b1111;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    key_n[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_after_rst", key_level, 4'b0000);
    repeat (5) tick();
    chk("t6_c5", key_level, 4'b0000);
    tick();
    chk("t6_c6", key_level, 4'b0001);

    // Random phase: bursty key activity, random consumes, rare resets.
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) begin
        int unsigned k;
        k = $urandom_range(0, 3);
        key_n[k] = ~key_n[k];
      end
      event_consume = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    event_consume = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
